sram_async_responder: RTL and testbench
=======================================

// Module: sram_async_responder
// PURPOSE
// - Synthesizable clocked stand-in for the external 128Kx16 async SRAM; the device end of the controller pin bus.
// - Samples ce_n/oe_n/we_n/addr on clk, answers reads with a programmable access latency and commits writes on the we_n rising edge.
// - Flags pulse-width and address-stability violations and counts completed transactions.
// - Used in simulation and on-FPGA loopback tests of the SRAM controller.
// PARAMETERS
// ADDR_W      17       pin address width
// DEPTH_LOG2  17       array depth = 2**DEPTH_LOG2 words; upper address bits ignored (aliasing)
// T_ACC_CYC   3        oe-low cycles before valid data appears (>=1)
// T_WP_CYC    2        minimum we_n-low cycles for a legal write (>=1)
// INV_PAT     16'hDEAD pattern driven while read access is pending
// PORTS
// clk         in   1       clock
// rst         in   1       reset, asynchronous, active-high
// sram_addr   in   ADDR_W  address pins
// sram_dq     inout 16     data pins
// sram_ce_n   in   1       chip enable, active-low
// sram_oe_n   in   1       output enable, active-low
// sram_we_n   in   1       write enable, active-low
// bd_we       in   1       backdoor write strobe (preload/inspect)
// bd_addr     in   DEPTH_LOG2  backdoor address
// bd_wdata    in   16      backdoor write data
// bd_rdata    out  16      backdoor read data, 1-cycle latency
// rd_count    out  16      completed reads (wraps 16'hFFFF->0)
// wr_count    out  16      committed writes (wraps)
// err_we_short   out 1     sticky: we_n pulse < T_WP_CYC
// err_addr_chg   out 1     sticky: address changed while we_n low
// BEHAVIOUR
// - Reset: state IDLE, dq hi-Z, counters 0, err flags 0, bd_rdata 0; array contents NOT cleared. Reset mid-op aborts with no commit.
// - All pins sampled at posedge clk; dq drive (dq_oe, dq_out) registered. "Cycle n" = n-th cycle the condition holds, n=0 first.
// - FSM IDLE/READ_ACC/READ_VAL/WRITE_LOW:
//   IDLE -> WRITE_LOW on ce_n=0 & we_n=0; -> READ_ACC on ce_n=0 & oe_n=0 & we_n=1.
//   we_n low has priority over oe_n low; dq never driven while we_n sampled low.
// - Read: cycle 0 hi-Z; cycles 1..T_ACC_CYC-1 drive INV_PAT; from cycle T_ACC_CYC drive mem[addr] (READ_VAL), tracking addr.
//   Addr change in READ_ACC/READ_VAL restarts access count (back to INV_PAT).
//   ce_n or oe_n sampled high -> IDLE, dq hi-Z next cycle.
//   rd_count += 1 on exit only if READ_VAL was reached.
// - Read to write: we_n sampled low during a read -> release dq next cycle, enter WRITE_LOW, no rd_count.
// - Write: on entry latch addr, count low cycles (we_cnt, saturating 8 bit), sample dq every low cycle.
//   Exit when we_n or ce_n sampled high:
//   we_cnt>=T_WP_CYC and no addr change -> mem[addr] = dq sampled in the last low cycle; wr_count += 1.
//   we_cnt<T_WP_CYC -> err_we_short=1, no commit.
//   Addr change while low -> err_addr_chg=1, no commit.
//   Return to IDLE, or directly to READ_ACC if ce_n=0 & oe_n=0.
// - Backdoor: bd_we writes mem[bd_addr] at posedge.
//   Same-cycle bus commit to same address: bus wins.
//   bd_rdata = mem[bd_addr] registered; reflects writes of the prior cycle.
// - ce_n high in any state -> IDLE immediately, dq hi-Z next cycle.
// STRUCTURE
// - Package sram_resp_pkg: state_t enum, INV_PAT default, counter width localparam.
// - Sub-module sram_resp_mem: 2**DEPTH_LOG2 x16 array.
//   Port A: bus read/commit. Port B: backdoor; sync write, registered read.
// - Top holds the FSM, timing counters, error flags and tri-state.
// TESTING
// - Preload mem[0x00123]=0xBEEF via backdoor; ce/oe low 5 cycles, addr 0x00123
//   -> dq Z,DEAD,DEAD,BEEF,BEEF; rd_count=1.
// - Write 0x1234 to 0x1FFFF, we_n low 3 cycles -> bd_rdata(0x1FFFF)=0x1234; wr_count=1; no errors.
// - we_n low 1 cycle (T_WP_CYC=2) -> err_we_short=1, memory unchanged, wr_count=0.
// - Addr 0x00010 -> 0x00011 during we_n low -> err_addr_chg=1, neither address written.
// - oe_n released at cycle 2 of a read -> dq hi-Z next cycle, rd_count unchanged.
//   rst pulse mid-write -> no commit, all outputs at reset values.
// - Controller loopback at CLK_MHZ=50: write 256 random words, read back -> all match; rd_count=wr_count=256.

Source files
------------

// File: rtl/sram_resp_pkg.sv
//------------------------------------------------------------------------------
// Module  : sram_resp_pkg
// Brief   : Shared types and constants for the async SRAM responder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sram_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_READ_ACC  = 2'd1,
    S_READ_VAL  = 2'd2,
    S_WRITE_LOW = 2'd3
  } state_t;

  localparam logic [15:0] INV_PAT_DEFAULT = 16'hDEAD;
  localparam int          CNT_W           = 16;
  localparam int          TCNT_W          = 8;

  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_resp_mem.sv
//------------------------------------------------------------------------------
// Module  : sram_resp_mem
// Brief   : 2**DEPTH_LOG2 x 16 array; port A bus read/commit, port B backdoor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_resp_mem #(
  parameter int DEPTH_LOG2 = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH_LOG2-1:0] i_a_raddr,
  output logic [15:0]           o_a_rdata,
  input  logic                  i_a_we,
  input  logic [DEPTH_LOG2-1:0] i_a_waddr,
  input  logic [15:0]           i_a_wdata,
  input  logic                  i_b_we,
  input  logic [DEPTH_LOG2-1:0] i_b_addr,
  input  logic [15:0]           i_b_wdata,
  output logic [15:0]           o_b_rdata
);

  logic [15:0] r_mem [0:(2**DEPTH_LOG2)-1];
  logic [15:0] r_b_rdata;

  // Port A is written last so a same-edge bus commit overrides the backdoor.
  always_ff @(posedge clk) begin
    if (i_b_we) r_mem[i_b_addr] <= i_b_wdata;
    if (i_a_we) r_mem[i_a_waddr] <= i_a_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_b_rdata <= '0;
    else     r_b_rdata <= r_mem[i_b_addr];
  end

  assign o_a_rdata = r_mem[i_a_raddr];
  assign o_b_rdata = r_b_rdata;

endmodule

`default_nettype wire

// File: rtl/sram_async_responder.sv
//------------------------------------------------------------------------------
// Module  : sram_async_responder
// Brief   : Clocked stand-in for a 128Kx16 async SRAM on the controller pin bus.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_async_responder
  import sram_resp_pkg::*;
#(
  parameter int          ADDR_W     = 17,
  parameter int          DEPTH_LOG2 = 17,
  parameter int          T_ACC_CYC  = 3,
  parameter int          T_WP_CYC   = 2,
  parameter logic [15:0] INV_PAT    = INV_PAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     sram_addr,
  inout  wire  [15:0]           sram_dq,
  input  logic                  sram_ce_n,
  input  logic                  sram_oe_n,
  input  logic                  sram_we_n,
  input  logic                  bd_we,
  input  logic [DEPTH_LOG2-1:0] bd_addr,
  input  logic [15:0]           bd_wdata,
  output logic [15:0]           bd_rdata,
  output logic [CNT_W-1:0]      rd_count,
  output logic [CNT_W-1:0]      wr_count,
  output logic                  err_we_short,
  output logic                  err_addr_chg
);

  localparam logic [TCNT_W-1:0] C_T_ACC = TCNT_W'(T_ACC_CYC);
  localparam logic [TCNT_W-1:0] C_T_WP  = TCNT_W'(T_WP_CYC);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [TCNT_W-1:0]   r_acc_cnt;
  logic [TCNT_W-1:0]   r_we_cnt;
  logic                r_rd_hit;
  logic                r_addr_bad;
  logic [15:0]         r_wdata;
  logic [15:0]         r_dq_out;
  logic                r_dq_oe;
  logic [CNT_W-1:0]    r_rd_count;
  logic [CNT_W-1:0]    r_wr_count;
  logic                r_err_we_short;
  logic                r_err_addr_chg;

  logic                w_ce;
  logic                w_oe;
  logic                w_we;
  logic                w_addr_chg;
  logic [TCNT_W-1:0]   w_acc_idx;
  logic                w_wr_exit;
  logic                w_wr_short;
  logic                w_commit;
  logic [15:0]         w_mem_rdata;

  assign w_ce       = ~sram_ce_n;
  assign w_oe       = ~sram_oe_n;
  assign w_we       = ~sram_we_n;
  assign w_addr_chg = (sram_addr != r_addr);
  // An address change mid-read counts as the first access cycle again.
  assign w_acc_idx  = w_addr_chg ? TCNT_W'(1) : r_acc_cnt;
  assign w_wr_exit  = (r_state == S_WRITE_LOW) && (!w_we || !w_ce);
  assign w_wr_short = (r_we_cnt < C_T_WP);
  assign w_commit   = w_wr_exit && !w_wr_short && !r_addr_bad && !rst;

  sram_resp_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_a_raddr (sram_addr[DEPTH_LOG2-1:0]),
    .o_a_rdata (w_mem_rdata),
    .i_a_we    (w_commit),
    .i_a_waddr (r_addr[DEPTH_LOG2-1:0]),
    .i_a_wdata (r_wdata),
    .i_b_we    (bd_we),
    .i_b_addr  (bd_addr),
    .i_b_wdata (bd_wdata),
    .o_b_rdata (bd_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_acc_cnt      <= '0;
      r_we_cnt       <= '0;
      r_rd_hit       <= 1'b0;
      r_addr_bad     <= 1'b0;
      r_wdata        <= '0;
      r_dq_out       <= '0;
      r_dq_oe        <= 1'b0;
      r_rd_count     <= '0;
      r_wr_count     <= '0;
      r_err_we_short <= 1'b0;
      r_err_addr_chg <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dq_oe <= 1'b0;
          if (w_ce && w_we) begin
            r_state    <= S_WRITE_LOW;
            r_addr     <= sram_addr;
            r_we_cnt   <= TCNT_W'(1);
            r_wdata    <= sram_dq;
            r_addr_bad <= 1'b0;
          end else if (w_ce && w_oe) begin
            r_state   <= S_READ_ACC;
            r_addr    <= sram_addr;
            r_acc_cnt <= TCNT_W'(1);
            r_rd_hit  <= 1'b0;
          end
        end
        S_READ_ACC, S_READ_VAL: begin
          if (w_ce && w_we) begin
            r_state    <= S_WRITE_LOW;
            r_dq_oe    <= 1'b0;
            r_addr     <= sram_addr;
            r_we_cnt   <= TCNT_W'(1);
            r_wdata    <= sram_dq;
            r_addr_bad <= 1'b0;
          end else if (!w_ce || !w_oe) begin
            r_state <= S_IDLE;
            r_dq_oe <= 1'b0;
            if (r_rd_hit) r_rd_count <= r_rd_count + 1'b1;
          end else begin
            r_addr    <= sram_addr;
            r_acc_cnt <= sat_inc(w_acc_idx);
            r_dq_oe   <= 1'b1;
            if (w_acc_idx >= C_T_ACC) begin
              r_state  <= S_READ_VAL;
              r_dq_out <= w_mem_rdata;
              r_rd_hit <= 1'b1;
            end else begin
              r_state  <= S_READ_ACC;
              r_dq_out <= INV_PAT;
            end
          end
        end
        S_WRITE_LOW: begin
          r_dq_oe <= 1'b0;
          if (w_wr_exit) begin
            if (w_wr_short) r_err_we_short <= 1'b1;
            if (r_addr_bad) r_err_addr_chg <= 1'b1;
            if (w_commit)   r_wr_count     <= r_wr_count + 1'b1;
            if (w_ce && w_oe) begin
              r_state   <= S_READ_ACC;
              r_addr    <= sram_addr;
              r_acc_cnt <= TCNT_W'(1);
              r_rd_hit  <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_we_cnt <= sat_inc(r_we_cnt);
            r_wdata  <= sram_dq;
            if (w_addr_chg) r_addr_bad <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sram_dq      = r_dq_oe ? r_dq_out : 16'bz;
  assign rd_count     = r_rd_count;
  assign wr_count     = r_wr_count;
  assign err_we_short = r_err_we_short;
  assign err_addr_chg = r_err_addr_chg;

endmodule

`default_nettype wire

// File: tb/tb_sram_async_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_sram_async_responder
// Brief   : Scoreboard-driven bench for the async SRAM responder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sram_async_responder;

  localparam int          ADDR_W = 17;
  localparam int          T_ACC  = 3;
  localparam logic [15:0] INV    = 16'hDEAD;
  // The data bus is pulled up, so a released bus reads all ones.
  localparam logic [15:0] HIZ    = 16'hFFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] sram_addr = '0;
  tri1  [15:0]       sram_dq;
  logic              ce_n = 1'b1;
  logic              oe_n = 1'b1;
  logic              we_n = 1'b1;
  logic              bd_we = 1'b0;
  logic [16:0]       bd_addr = '0;
  logic [15:0]       bd_wdata = '0;
  logic [15:0]       bd_rdata;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;
  logic              err_we_short;
  logic              err_addr_chg;
  logic              tb_dq_oe = 1'b0;
  logic [15:0]       tb_dq = '0;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  assign sram_dq = tb_dq_oe ? tb_dq : 16'bz;

  always #10 clk = ~clk;

  sram_async_responder dut (
    .clk          (clk),
    .rst          (rst),
    .sram_addr    (sram_addr),
    .sram_dq      (sram_dq),
    .sram_ce_n    (ce_n),
    .sram_oe_n    (oe_n),
    .sram_we_n    (we_n),
    .bd_we        (bd_we),
    .bd_addr      (bd_addr),
    .bd_wdata     (bd_wdata),
    .bd_rdata     (bd_rdata),
    .rd_count     (rd_count),
    .wr_count     (wr_count),
    .err_we_short (err_we_short),
    .err_addr_chg (err_addr_chg)
  );

  task automatic apply_reset();
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; tb_dq_oe = 1'b0; bd_we = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic bd_write(input logic [16:0] a, input logic [15:0] d);
    bd_addr = a; bd_wdata = d; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic bd_read(input logic [16:0] a, output logic [15:0] d);
    bd_addr = a;
    @(negedge clk);
    d = bd_rdata;
  endtask

  task automatic bus_write(input logic [16:0] a, input logic [15:0] d, input int n);
    sram_addr = a; tb_dq = d; tb_dq_oe = 1'b1; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    repeat (n) @(negedge clk);
    we_n = 1'b1; ce_n = 1'b1;
    @(negedge clk);
    tb_dq_oe = 1'b0;
  endtask

  task automatic test_reset();
    #5 rst = 1'b1;
    @(negedge clk);
    checks += 5;
    if (rd_count !== 16'd0)     begin errors++; $display("FAIL reset_rd_count got %h exp 0000", rd_count); end
    if (wr_count !== 16'd0)     begin errors++; $display("FAIL reset_wr_count got %h exp 0000", wr_count); end
    if ({err_we_short, err_addr_chg} !== 2'b00)
                                begin errors++; $display("FAIL reset_err got %b exp 00", {err_we_short, err_addr_chg}); end
    if (bd_rdata !== 16'd0)     begin errors++; $display("FAIL reset_bd_rdata got %h exp 0000", bd_rdata); end
    if (sram_dq !== HIZ)        begin errors++; $display("FAIL reset_dq got %h exp %h", sram_dq, HIZ); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [15:0] seq [5];
    logic [15:0] exp;
    seq = '{HIZ, INV, INV, 16'hBEEF, 16'hBEEF};
    apply_reset();
    bd_write(17'h00123, 16'hBEEF);
    sram_addr = 17'h00123; ce_n = 1'b0; oe_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(seq[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (sram_dq !== exp) begin errors++; $display("FAIL read_dq cyc%0d got %h exp %h", i, sram_dq, exp); end
    end
    ce_n = 1'b1; oe_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if (sram_dq !== HIZ)    begin errors++; $display("FAIL read_release_dq got %h exp %h", sram_dq, HIZ); end
    if (rd_count !== 16'd1) begin errors++; $display("FAIL read_rd_count got %0d exp 1", rd_count); end
  endtask

  task automatic test_write();
    logic [15:0] d;
    apply_reset();
    bus_write(17'h1FFFF, 16'h1234, 3);
    bd_read(17'h1FFFF, d);
    checks += 3;
    if (d !== 16'h1234)     begin errors++; $display("FAIL write_mem got %h exp 1234", d); end
    if (wr_count !== 16'd1) begin errors++; $display("FAIL write_wr_count got %0d exp 1", wr_count); end
    if ({err_we_short, err_addr_chg} !== 2'b00)
                            begin errors++; $display("FAIL write_err got %b exp 00", {err_we_short, err_addr_chg}); end
  endtask

  task automatic test_we_short();
    logic [15:0] d;
    apply_reset();
    bd_write(17'h00400, 16'h4242);
    bus_write(17'h00400, 16'h9999, 1);
    bd_read(17'h00400, d);
    checks += 3;
    if (err_we_short !== 1'b1) begin errors++; $display("FAIL short_err got %b exp 1", err_we_short); end
    if (d !== 16'h4242)        begin errors++; $display("FAIL short_mem got %h exp 4242", d); end
    if (wr_count !== 16'd0)    begin errors++; $display("FAIL short_wr_count got %0d exp 0", wr_count); end
  endtask

  task automatic test_addr_chg();
    logic [15:0] d0, d1;
    apply_reset();
    bd_write(17'h00010, 16'h0A0A);
    bd_write(17'h00011, 16'h0B0B);
    sram_addr = 17'h00010; tb_dq = 16'h7777; tb_dq_oe = 1'b1; ce_n = 1'b0; we_n = 1'b0;
    @(negedge clk);
    sram_addr = 17'h00011;
    @(negedge clk);
    we_n = 1'b1; ce_n = 1'b1;
    @(negedge clk);
    tb_dq_oe = 1'b0;
    bd_read(17'h00010, d0);
    bd_read(17'h00011, d1);
    checks += 5;
    if (err_addr_chg !== 1'b1) begin errors++; $display("FAIL achg_err got %b exp 1", err_addr_chg); end
    if (err_we_short !== 1'b0) begin errors++; $display("FAIL achg_short got %b exp 0", err_we_short); end
    if (d0 !== 16'h0A0A)       begin errors++; $display("FAIL achg_mem10 got %h exp 0a0a", d0); end
    if (d1 !== 16'h0B0B)       begin errors++; $display("FAIL achg_mem11 got %h exp 0b0b", d1); end
    if (wr_count !== 16'd0)    begin errors++; $display("FAIL achg_wr_count got %0d exp 0", wr_count); end
  endtask

  task automatic test_oe_release();
    logic [15:0] seq [3];
    logic [15:0] exp;
    seq = '{HIZ, INV, HIZ};
    apply_reset();
    sram_addr = 17'h00123; ce_n = 1'b0; oe_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) oe_n = 1'b1;
      exp_q.push_back(seq[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (sram_dq !== exp) begin errors++; $display("FAIL oerel_dq cyc%0d got %h exp %h", i, sram_dq, exp); end
    end
    ce_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_count !== 16'd0) begin errors++; $display("FAIL oerel_rd_count got %0d exp 0", rd_count); end
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] d;
    apply_reset();
    bd_write(17'h00200, 16'h5555);
    sram_addr = 17'h00200; tb_dq = 16'hAAAA; tb_dq_oe = 1'b1; ce_n = 1'b0; we_n = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; we_n = 1'b1; ce_n = 1'b1; tb_dq_oe = 1'b0;
    #1;
    checks += 4;
    if (wr_count !== 16'd0)  begin errors++; $display("FAIL rstw_wr_count got %0d exp 0", wr_count); end
    if ({err_we_short, err_addr_chg} !== 2'b00)
                             begin errors++; $display("FAIL rstw_err got %b exp 00", {err_we_short, err_addr_chg}); end
    if (bd_rdata !== 16'd0)  begin errors++; $display("FAIL rstw_bd_rdata got %h exp 0000", bd_rdata); end
    if (sram_dq !== HIZ)     begin errors++; $display("FAIL rstw_dq got %h exp %h", sram_dq, HIZ); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bd_read(17'h00200, d);
    checks += 2;
    if (d !== 16'h5555)     begin errors++; $display("FAIL rstw_mem got %h exp 5555", d); end
    if (wr_count !== 16'd0) begin errors++; $display("FAIL rstw_wr_count2 got %0d exp 0", wr_count); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] addrs [256];
    logic [15:0] data  [256];
    logic [15:0] exp;
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      addrs[i] = 17'(i * 499 + 64);
      data[i]  = 16'($urandom);
      bus_write(addrs[i], data[i], 2);
    end
    for (int i = 0; i < 256; i++) begin
      sram_addr = addrs[i]; ce_n = 1'b0; oe_n = 1'b0;
      for (int c = 0; c <= T_ACC; c++) begin
        exp_q.push_back((c == 0) ? HIZ : ((c < T_ACC) ? INV : data[i]));
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (sram_dq !== exp) begin
          errors++;
          $display("FAIL loop_dq word%0d cyc%0d got %h exp %h", i, c, sram_dq, exp);
        end
      end
      ce_n = 1'b1; oe_n = 1'b1;
      @(negedge clk);
    end
    checks += 2;
    if (rd_count !== 16'd256) begin errors++; $display("FAIL loop_rd_count got %0d exp 256", rd_count); end
    if (wr_count !== 16'd256) begin errors++; $display("FAIL loop_wr_count got %0d exp 256", wr_count); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks %0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_we_short();
    test_addr_chg();
    test_oe_release();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
